// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - opcode, ALU-field, class and condition codes shared by encoder and decoder
package instr_pkg;

  localparam logic [4:0] OP_AND  = 5'h00;
  localparam logic [4:0] OP_EOR  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_RSB  = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_ADC  = 5'h05;
  localparam logic [4:0] OP_SBC  = 5'h06;
  localparam logic [4:0] OP_TST  = 5'h08;
  localparam logic [4:0] OP_CMP  = 5'h0A;
  localparam logic [4:0] OP_CMN  = 5'h0B;
  localparam logic [4:0] OP_ORR  = 5'h0C;
  localparam logic [4:0] OP_MOV  = 5'h0D;
  localparam logic [4:0] OP_BIC  = 5'h0E;
  localparam logic [4:0] OP_MVN  = 5'h0F;
  localparam logic [4:0] OP_LDR  = 5'h10;
  localparam logic [4:0] OP_LDRB = 5'h11;
  localparam logic [4:0] OP_STR  = 5'h12;
  localparam logic [4:0] OP_STRB = 5'h13;
  localparam logic [4:0] OP_B    = 5'h14;
  localparam logic [4:0] OP_BL   = 5'h15;
  localparam logic [4:0] OP_BEQ  = 5'h16;
  localparam logic [4:0] OP_BNE  = 5'h17;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LDST   = 3'b010;
  localparam logic [2:0] CLS_BRANCH = 3'b101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_AL = 4'hE;

endpackage

// File: rtl/instr_encode_core.sv
// rtl/instr_encode_core.sv - combinational field-bundle to 32-bit instruction word mapping
module instr_encode_core
  import instr_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [3:0]  condition,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [11:0] immediate,
  input  logic [23:0] branch_offset,
  input  logic [4:0]  shift_amount,
  input  logic [1:0]  shift_type,
  input  logic        immediate_flag,
  input  logic        flags_update_en,
  output logic [31:0] word,
  output logic        invalid
);

  logic [3:0] alu;
  logic       is_dp;
  logic       is_load;

  always_comb begin
    alu   = '0;
    is_dp = 1'b1;
    case (opcode)
      OP_AND:  alu = ALU_AND;
      OP_EOR:  alu = ALU_EOR;
      OP_SUB:  alu = ALU_SUB;
      OP_RSB:  alu = ALU_RSB;
      OP_ADD:  alu = ALU_ADD;
      OP_ADC:  alu = ALU_ADC;
      OP_SBC:  alu = ALU_SBC;
      OP_TST:  alu = ALU_TST;
      OP_CMP:  alu = ALU_CMP;
      OP_CMN:  alu = ALU_CMN;
      OP_ORR:  alu = ALU_ORR;
      OP_MOV:  alu = ALU_MOV;
      OP_BIC:  alu = ALU_BIC;
      OP_MVN:  alu = ALU_MVN;
      default: is_dp = 1'b0;
    endcase
  end

  assign is_load = (opcode == OP_LDR) || (opcode == OP_LDRB);

  always_comb begin
    word    = '0;
    invalid = 1'b0;
    if (is_dp) begin
      word[31:28] = condition;
      word[27:25] = immediate_flag ? CLS_DP_IMM : CLS_DP_REG;
      word[24:21] = alu;
      // compare-type ops are meaningless without flag update
      word[20]    = (alu == ALU_TST || alu == ALU_CMP || alu == ALU_CMN) ? 1'b1 : flags_update_en;
      word[19:16] = rs1;
      word[15:12] = rd;
      word[11:0]  = immediate_flag ? immediate : {shift_amount, shift_type, 1'b0, rs2};
    end else begin
      case (opcode)
        OP_LDR, OP_LDRB, OP_STR, OP_STRB: begin
          word[31:28] = condition;
          word[27:25] = CLS_LDST;
          word[22]    = (opcode == OP_LDRB) || (opcode == OP_STRB);
          word[20]    = is_load;
          word[19:16] = rs1;
          word[15:12] = is_load ? rd : rs2;
          word[11:0]  = immediate;
        end
        OP_B, OP_BL, OP_BEQ, OP_BNE: begin
          word[31:28] = (opcode == OP_BEQ) ? COND_EQ :
                        (opcode == OP_BNE) ? COND_NE : condition;
          word[27:25] = CLS_BRANCH;
          word[24]    = (opcode == OP_BL);
          word[23:0]  = branch_offset;
        end
        default: invalid = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - load-run FSM writing encoded words to instruction memory
// Optional INSTR_ENC_STATS_EN adds saturating enc_count/err_count outputs.
module instruction_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [3:0]        condition,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [11:0]       immediate,
  input  logic [23:0]       branch_offset,
  input  logic [4:0]        shift_amount,
  input  logic [1:0]        shift_type,
  input  logic              immediate_flag,
  input  logic              flags_update_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [4:0]        err_opcode
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]       enc_count,
  output logic [15:0]       err_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] acc_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [31:0]       enc_word;
  logic              enc_invalid;
  logic              accept;
  logic              wr_fire;

  instr_encode_core u_core (
    .opcode          (opcode),
    .condition       (condition),
    .rd              (rd),
    .rs1             (rs1),
    .rs2             (rs2),
    .immediate       (immediate),
    .branch_offset   (branch_offset),
    .shift_amount    (shift_amount),
    .shift_type      (shift_type),
    .immediate_flag  (immediate_flag),
    .flags_update_en (flags_update_en),
    .word            (enc_word),
    .invalid         (enc_invalid)
  );

  assign in_ready = (state == S_RUN) && (acc_cnt < len_q) && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_fire  = mem_we && mem_ready;
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      err_opcode <= '0;
    end else begin
      if (wr_fire) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(1);
        wr_cnt   <= wr_cnt + ADDR_W'(1);
      end
      // a new accept overrides the drain above, giving one word per cycle
      if (accept) begin
        if (enc_invalid) begin
          if (!err) begin
            err        <= 1'b1;
            err_opcode <= opcode;
          end
        end else begin
          mem_we    <= 1'b1;
          mem_wdata <= enc_word;
          acc_cnt   <= acc_cnt + ADDR_W'(1);
        end
      end
      case (state)
        S_IDLE: if (start) begin
          len_q      <= length;
          mem_addr   <= base_addr;
          acc_cnt    <= '0;
          wr_cnt     <= '0;
          err        <= 1'b0;
          err_opcode <= '0;
          state      <= (length == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (wr_cnt == len_q && !mem_we) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (wr_fire && enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
      if (accept && enc_invalid && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-002 SHALL have one clock; reset is synchronous and active-low.
REQ-003 SHALL have `clk` (input, 1): the clock.
REQ-004 SHALL have `rst_n` (input, 1): synchronous active-low reset.
REQ-005 SHALL have `start` (input, 1): begins a load run.
REQ-006 SHALL have `base_addr` (input, ADDR_W): first write address, sampled on `start`.
REQ-007 SHALL have `length` (input, ADDR_W): words to write, sampled on `start`.
REQ-008 SHALL have `in_valid` (input, 1) and `in_ready` (output, 1): field-bundle handshake.
REQ-009 SHALL have inputs `opcode` (5), `condition` (4), `rd`, `rs1` and `rs2` (4 each), `immediate` (12), `branch_offset` (24), `shift_amount` (5), `shift_type` (2), `immediate_flag` (1) and `flags_update_en` (1): the instruction fields.
REQ-010 SHALL have `mem_we` (output, 1), `mem_addr` (output, ADDR_W), `mem_wdata` (output, 32) and `mem_ready` (input, 1): the memory write port.
REQ-011 SHALL have `busy` (output, 1), `done` (output, 1), `err` (output, 1) and `err_opcode` (output, 5): status.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on `start`, or IDLE->DONE on `start` with `length`=0.
- RUN->DONE when written count equals `length` and no write is pending.
- DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL ignore `start` outside IDLE.
REQ-014 SHALL drive `in_ready` = RUN && (accepted count < `length`) && (!`mem_we` || `mem_ready`).
REQ-015 SHALL register the encoded word on an accepted bundle at edge N and assert `mem_we` from cycle N+1 until `mem_ready`; `mem_we`/`mem_addr`/`mem_wdata` are held stable while stalled.
REQ-016 SHALL increment `mem_addr` by 1 on each `mem_we && mem_ready`, wrapping modulo 2^ADDR_W.
REQ-017 SHALL allow back-to-back acceptance with `mem_ready` high continuously, giving one word per cycle.
REQ-018 SHALL encode data-processing instructions (ALU ops AND/EOR/SUB/RSB/ADD/ADC/SBC/TST/CMP/CMN/ORR/MOV/BIC/MVN, fields 0000..1111 excluding 0111 and 1001) as:
- [31:28] cond; [27:25] 001 if `immediate_flag`, else 000; [24:21] ALU field; [20] S; [19:16] rs1; [15:12] rd.
- [11:0] immediate, or {shift_amount, shift_type, 1'b0, rs2}.
REQ-019 SHALL force S=1 for TST/CMP/CMN, and otherwise set S=`flags_update_en`.
REQ-020 SHALL encode LDR/LDRB/STR/STRB as:
- [27:25] 010; [22] byte; [20] load; [19:16] rs1; [11:0] immediate; other bits in [24:21] 0.
- [15:12] = rd for loads and rs2 for stores.
REQ-021 SHALL encode branches as [27:25] 101, [23:0] branch_offset, with [24]=1 for BL only.
- B and BL use `condition`.
- BEQ forces cond 0000; BNE forces cond 0001.
REQ-022 SHALL treat any other opcode, including 11111, as invalid.
- Invalid bundles are consumed but neither written nor counted.
- `err` is set, and `err_opcode` captures the opcode of the first invalid bundle in the run.
REQ-023 SHALL hold `busy`=1 in RUN and `done`=1 for the single DONE cycle.

Reset
REQ-024 SHALL on `rst_n`=0 at a clock edge enter IDLE and drive `mem_we`, `in_ready`, `busy`, `done` and `err` to 0, `mem_addr` to 0, `mem_wdata` to 0 and `err_opcode` to 0, discarding any pending write.
REQ-025 SHALL clear `err` and `err_opcode` on an accepted `start`.

Configuration
REQ-026 SHALL, when `INSTR_ENC_STATS_EN` is defined, add outputs `enc_count` (16) and `err_count` (16), saturating at 0xFFFF, cleared on reset only, incremented per written word and per invalid bundle respectively.
REQ-027 SHALL, when `INSTR_ENC_STATS_EN` is undefined, omit those ports and their counters.

Structure
REQ-028 SHALL take the OP_* opcode codes, ALU-field constants, the class codes (000/001/010/101) and the COND_AL/EQ/NE constants from shared package instr_pkg, shared with the decoder.
REQ-029 SHALL place the field-to-word mapping plus the invalid flag in the combinational sub-module instr_encode_core; the FSM, counters and output register stay in instruction_encoder.

Verification
REQ-030 SHALL cover: ADD, immediate_flag=1, rd=1, rs1=2, imm=0x005, cond=1110 -> mem_wdata 0xE2821005, mem_we one cycle after acceptance.
REQ-031 SHALL cover: SUB register form, S=1, rd=3, rs1=4, rs2=5, shift 0 -> 0xE0543005; CMP with flags_update_en=0 -> bit20=1.
REQ-032 SHALL cover: LDR rd=0, rs1=1, imm=4 -> 0xE4110004; BL offset 0x000010 -> 0xEB000010; BEQ offset 3 -> 0x0A000003; BNE offset 3 -> 0x1A000003.
REQ-033 SHALL cover: base_addr=0x3FE, length=4, mem_ready toggling 1/0 -> addresses 3FE, 3FF, 000, 001 with data held during stalls, then one-cycle done.
REQ-034 SHALL cover: opcode 11111 mid-run -> err=1, err_opcode=11111, no write, addresses contiguous; length=0 -> done on the cycle after start with no writes.
REQ-035 SHALL cover: rst_n=0 while mem_we is stalled -> all outputs 0 next cycle, state IDLE; a subsequent start works normally.
